// File: rtl/logic_op_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// logic_op_pkg : opcode encodings, operand limits and the N-operand fold (rev 1.0)
// ----------------------------------------------------------------------------
package logic_op_pkg;

  localparam int MAX_NUM_IN = 8;
  localparam int MAX_WIDTH  = 64;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_PASS = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef logic [MAX_WIDTH-1:0] word_t;

  // Operands at index >= num_in are ignored; callers truncate to their width.
  function automatic word_t fold_op(input word_t operands [MAX_NUM_IN],
                                    input int    num_in,
                                    input op_e   op);
    word_t acc_and;
    word_t acc_or;
    word_t acc_xor;
    word_t res;
    acc_and = operands[0];
    acc_or  = operands[0];
    acc_xor = operands[0];
    for (int k = 1; k < MAX_NUM_IN; k++) begin
      if (k < num_in) begin
        acc_and = acc_and & operands[k];
        acc_or  = acc_or  | operands[k];
        acc_xor = acc_xor ^ operands[k];
      end
    end
    case (op)
      OP_AND:  res = acc_and;
      OP_OR:   res = acc_or;
      OP_XOR:  res = acc_xor;
      OP_NAND: res = ~acc_and;
      OP_NOR:  res = ~acc_or;
      OP_XNOR: res = ~acc_xor;
      OP_PASS: res = operands[0];
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/logic_op_pipe_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_stage : generic valid/ready register slice with full backpressure (rev 1.0)
// ----------------------------------------------------------------------------
module pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  // Payload only loads on a real transfer so an emptied stage keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/logic_op_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// logic_op_pipe : 2-stage N-operand bitwise logic unit, valid/ready (rev 1.0)
// Optional X/Z detection with x_flag output: LOGIC_OP_PIPE_X_DETECT_EN
// ----------------------------------------------------------------------------
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH*NUM_IN-1:0] in_data,
  input  logic [2:0]              in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_red,
  output logic [CNT_W-1:0]        out_cnt
`ifdef LOGIC_OP_PIPE_X_DETECT_EN
  ,
  output logic                    x_flag
`endif
);

  localparam int S1_W = WIDTH*NUM_IN + 3;
`ifdef LOGIC_OP_PIPE_X_DETECT_EN
  localparam int S2_W = WIDTH + 2;
`else
  localparam int S2_W = WIDTH + 1;
`endif

  logic            s1_valid;
  logic            s1_out_ready;
  logic [S1_W-1:0] s1_q;
  logic [S2_W-1:0] s2_d;
  logic [S2_W-1:0] s2_q;
  logic [WIDTH-1:0] result;
  word_t           ops [MAX_NUM_IN];

  pipe_stage #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_op, in_data}),
    .out_valid (s1_valid),
    .out_ready (s1_out_ready),
    .out_data  (s1_q)
  );

  for (genvar k = 0; k < MAX_NUM_IN; k++) begin : g_ops
    if (k < NUM_IN) begin : g_live
      assign ops[k] = word_t'(s1_q[k*WIDTH +: WIDTH]);
    end else begin : g_pad
      assign ops[k] = '0;
    end
  end

  assign result = WIDTH'(fold_op(ops, NUM_IN, op_e'(s1_q[S1_W-1 -: 3])));

`ifdef LOGIC_OP_PIPE_X_DETECT_EN
  logic             xf;
  logic [WIDTH-1:0] res_x;
  // Any X/Z operand bit poisons the XOR reduction, which case-equality can see.
  assign xf    = ((^s1_q[WIDTH*NUM_IN-1:0]) === 1'bx);
  assign res_x = xf ? {WIDTH{1'bx}} : result;
  assign s2_d  = {xf, &res_x, res_x};
  assign x_flag = s2_q[WIDTH+1];
`else
  assign s2_d  = {&result, result};
`endif

  pipe_stage #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s1_out_ready),
    .in_data   (s2_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign out_data = s2_q[WIDTH-1:0];
  assign out_red  = s2_q[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else if (out_valid && out_ready) begin
      out_cnt <= out_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire
